// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg
// Shared constants and types for the FIFO drain stage (fifo_reader) and its
// two-entry output buffer (reader_skid_buf).
//   DATA_W_DEFAULT : default data width, matching the FIFO d_out bus.
//   CNT_W_DEFAULT  : default width of the pop statistics counter. It is only
//                    used when FIFO_READER_STAT_EN is defined.
//   occ_e          : output buffer occupancy, which is also the FSM state.
package fifo_reader_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int CNT_W_DEFAULT  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/reader_skid_buf.sv
// reader_skid_buf
// Two-entry shift buffer that sits between the FIFO read port and the stream
// output. Entry 0 is always the head. Entry 1 holds the second word while the
// consumer stalls. The occupancy FSM (EMPTY/ONE/TWO) is exported, so the
// wrapper can budget FIFO reads against the free slots.
// Ports:
//   clk        : rising-edge clock
//   reset_n    : synchronous active-low reset; clears the state and both entries
//   i_push     : write i_pushData into the tail slot this edge
//   i_pushData : word to write
//   i_pop      : remove the head this edge (ignored when EMPTY)
//   o_occ      : current occupancy
//   o_head     : head entry (entry 0)
module reader_skid_buf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_pushData,
  input  logic              i_pop,
  output occ_e              o_occ,
  output logic [DATA_W-1:0] o_head
);

  occ_e              r_state;
  occ_e              w_nextState;
  logic [DATA_W-1:0] r_entry0;
  logic [DATA_W-1:0] r_entry1;
  logic              w_load0;
  logic              w_load1;
  logic              w_shift;

  // Occupancy state register. Reset returns to EMPTY, which discards any
  // buffered words.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and entry write controls.
  // In ONE, a simultaneous push and pop overwrites the head directly, so the
  // new word becomes head on the next cycle without passing through entry 1.
  // In TWO a push cannot happen, because the wrapper never issues a read that
  // could land there. Only the pop-and-shift path exists in that state.
  always_comb begin
    w_nextState = r_state;
    w_load0     = 1'b0;
    w_load1     = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (i_push) begin
          w_nextState = ONE;
          w_load0     = 1'b1;
        end
      end
      ONE: begin
        if (i_push && i_pop) begin
          w_load0 = 1'b1;
        end else if (i_push) begin
          w_nextState = TWO;
          w_load1     = 1'b1;
        end else if (i_pop) begin
          w_nextState = EMPTY;
        end
      end
      TWO: begin
        if (i_pop) begin
          w_nextState = ONE;
          w_shift     = 1'b1;
        end
      end
      default: begin
        w_nextState = EMPTY;
      end
    endcase
  end

  // Data entries. The head is either loaded with a fresh word or refilled
  // from entry 1 when the buffer drains from TWO to ONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
    end else begin
      if (w_load0) begin
        r_entry0 <= i_pushData;
      end else if (w_shift) begin
        r_entry0 <= r_entry1;
      end
      if (w_load1) begin
        r_entry1 <= i_pushData;
      end
    end
  end

  assign o_occ  = r_state;
  assign o_head = r_entry0;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader
// Drain stage for the 8-entry, 32-bit synchronous FIFO. It issues FIFO reads,
// captures each returned word into a two-entry buffer and presents the words
// on a valid/ready stream. The two buffer slots cover the FIFO's one-cycle
// registered read latency, so reads can run back to back while the consumer
// keeps up. The consumer can still stall at any time without losing words.
// Optional feature macro: FIFO_READER_STAT_EN adds the rd_count and
// err_sticky ports and their logic.
// Ports:
//   clk         : rising-edge clock
//   reset_n     : synchronous active-low reset
//   en          : allow new FIFO reads. Buffered and in-flight words drain regardless.
//   fifo_empty  : FIFO empty flag
//   fifo_rd_ack : FIFO read acknowledge, with valid fifo_d_out
//   fifo_rd_err : FIFO read error (read issued on empty)
//   fifo_d_out  : FIFO read data
//   fifo_rd_en  : FIFO read request
//   m_valid     : stream data valid
//   m_ready     : stream consumer ready
//   m_data      : stream data (buffer head)
//   busy        : buffer non-empty or read in flight
//   rd_count    : (FIFO_READER_STAT_EN) stream pops, wrapping
//   err_sticky  : (FIFO_READER_STAT_EN) any read error or missing ack seen
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
`ifdef FIFO_READER_STAT_EN
  ,
  parameter int CNT_W = CNT_W_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic              fifo_rd_ack,
  input  logic              fifo_rd_err,
  input  logic [DATA_W-1:0] fifo_d_out,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy
`ifdef FIFO_READER_STAT_EN
  ,
  output logic [CNT_W-1:0]  rd_count,
  output logic              err_sticky
`endif
);

  occ_e              w_occ;
  logic [DATA_W-1:0] w_head;
  logic              r_inflight;
  logic              w_push;
  logic              w_pop;
  logic              w_rdEn;
  logic [2:0]        w_used;

  // A word is captured only for a read that is actually in flight. A response
  // that flags an error, or brings neither ack nor err, releases the slot
  // credit and writes nothing. The wrapper therefore never waits on a
  // response that will not come. If ack and err arrive together, the
  // response is treated as a failed read.
  assign w_push = r_inflight & fifo_rd_ack & ~fifo_rd_err;
  assign w_pop  = m_valid & m_ready;

  // Slots committed after this edge: buffered words plus the outstanding
  // read, less the word leaving on this edge. A pop frees its slot in the
  // same cycle. This lets a new read go out while the head is consumed,
  // which gives one word per cycle in steady state. The occupancy never
  // exceeds two, because at most one read is in flight.
  assign w_used = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rdEn = reset_n & en & ~fifo_empty & (w_used < 3'd2);

  // In-flight flag. It is set for exactly the cycle in which the FIFO answers
  // a read. Reset clears it, so an ack arriving after reset is ignored.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rdEn;
    end
  end

  reader_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skidBuf (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_push),
    .i_pushData (fifo_d_out),
    .i_pop      (w_pop),
    .o_occ      (w_occ),
    .o_head     (w_head)
  );

  assign fifo_rd_en = w_rdEn;
  assign m_valid    = (w_occ != EMPTY);
  assign m_data     = w_head;
  assign busy       = (w_occ != EMPTY) | r_inflight;

`ifdef FIFO_READER_STAT_EN
  logic [CNT_W-1:0] r_rdCount;
  logic             r_errSticky;

  // Statistics. The pop counter wraps naturally. The error flag latches any
  // FIFO error, and any in-flight cycle without an ack, until the next reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdCount   <= '0;
      r_errSticky <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rdCount <= r_rdCount + CNT_W'(1);
      end
      if (fifo_rd_err || (r_inflight && !fifo_rd_ack)) begin
        r_errSticky <= 1'b1;
      end
    end
  end

  assign rd_count   = r_rdCount;
  assign err_sticky = r_errSticky;
`endif

endmodule
